// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared types and helpers for the convolution output
//                sequencer: FSM state encoding and output-count arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    // Sequencer states; 3-bit encoding covers all six states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT_X = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_MAC    = 3'd3,
        ST_OUT    = 3'd4,
        ST_DONE   = 3'd5
    } conv_state_e;

    // Number of window positions across one frame
    function automatic int calc_n_out(input int x_size, input int f_size, input int stride);
        return (x_size - f_size) / stride + 1;
    endfunction

    // Index width that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that saturates at MAX. A clear restarts the
//                count from zero while a coincident inc still counts, so the
//                result of clear+inc is 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] w_base;

    // Next count: optional clear first, then a saturating increment
    always_comb begin
        w_base  = clear ? '0 : count_q;
        count_d = w_base;
        if (inc && (w_base != c_max)) begin
            count_d = w_base + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/conv_out_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_out_sequencer
//  Description : Walks a convolution window across an X frame, waiting for
//                enough X words, issuing one MAC per (position, filter) pair
//                and handing each result downstream with valid/ready.
//                Optional macro CONV_OUT_PERF_EN enables the output
//                back-pressure stall counter on stall_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_out_sequencer
    import conv_pkg::*;
#(
    parameter int X_MEM_SIZE = 8,
    parameter int F_MEM_SIZE = 4,
    parameter int STRIDE     = 1,
    parameter int NUM_F      = 1,
    localparam int X_MEM_ADDR_WIDTH = $clog2(X_MEM_SIZE),
    localparam int F_SEL_WIDTH      = clog2_min1(NUM_F),
    localparam int N_OUT            = calc_n_out(X_MEM_SIZE, F_MEM_SIZE, STRIDE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        conv_start,
    input  logic                        x_wr_en,
    input  logic                        mac_done,
    input  logic                        m_ready_y,
    output logic                        mac_start,
    output logic [X_MEM_ADDR_WIDTH-1:0] x_base_addr,
    output logic [F_SEL_WIDTH-1:0]      f_sel,
    output logic                        m_valid_y,
    output logic                        y_last,
    output logic                        conv_done,
    output logic                        busy,
    output logic [15:0]                 stall_cnt
);

    localparam int                     XCNT_WIDTH = $clog2(X_MEM_SIZE + 1);
    localparam int                     POS_WIDTH  = clog2_min1(N_OUT);
    localparam logic [POS_WIDTH-1:0]   c_pos_last = POS_WIDTH'(N_OUT - 1);
    localparam logic [F_SEL_WIDTH-1:0] c_f_last   = F_SEL_WIDTH'(NUM_F - 1);
    localparam logic [31:0]            c_f_taps   = 32'(F_MEM_SIZE);

    conv_state_e                 state_q, state_d;
    logic                        conv_start_q;
    logic [POS_WIDTH-1:0]        pos_q, pos_d;
    logic [F_SEL_WIDTH-1:0]      f_sel_q, f_sel_d;
    logic [X_MEM_ADDR_WIDTH-1:0] x_base_addr_q, x_base_addr_d;
    logic [XCNT_WIDTH-1:0]       x_count;

    logic                        w_start;
    logic                        w_last;
    logic                        w_x_ready;
    logic [31:0]                 w_x_avail;
    logic [31:0]                 w_x_need;

    // A frame starts only on a conv_start edge seen while idle
    assign w_start   = (state_q == ST_IDLE) && conv_start && !conv_start_q;
    assign w_last    = (pos_q == c_pos_last) && (f_sel_q == c_f_last);
    // A write landing this cycle already counts toward the current window
    assign w_x_avail = 32'(x_count) + 32'(x_wr_en);
    assign w_x_need  = 32'(x_base_addr_q) + c_f_taps;
    assign w_x_ready = (w_x_avail >= w_x_need);

    // Next-state, index advance and per-state output decode
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        f_sel_d   = f_sel_q;
        mac_start = 1'b0;
        m_valid_y = 1'b0;
        y_last    = 1'b0;
        conv_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d = ST_WAIT_X;
                    pos_d   = '0;
                    f_sel_d = '0;
                end
            end
            ST_WAIT_X: begin
                if (w_x_ready) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mac_start = 1'b1;
                state_d   = ST_MAC;
            end
            ST_MAC: begin
                if (mac_done) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                m_valid_y = 1'b1;
                y_last    = w_last;
                if (m_ready_y) begin
                    if (w_last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_X;
                        // Filters cycle fastest; the window moves on filter wrap
                        if (f_sel_q == c_f_last) begin
                            f_sel_d = '0;
                            pos_d   = pos_q + 1'b1;
                        end else begin
                            f_sel_d = f_sel_q + 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                conv_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Registered base address follows the next window position
        x_base_addr_d = X_MEM_ADDR_WIDTH'(32'(pos_d) * 32'(STRIDE));
    end

    // State, indices and edge-detect register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            // Treat conv_start as already high so a level held across
            // reset release is not mistaken for a fresh start request
            conv_start_q  <= 1'b1;
            pos_q         <= '0;
            f_sel_q       <= '0;
            x_base_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            conv_start_q  <= conv_start;
            pos_q         <= pos_d;
            f_sel_q       <= f_sel_d;
            x_base_addr_q <= x_base_addr_d;
        end
    end

    // X words available; restarts in DONE so the next frame counts fresh
    sat_counter #(
        .WIDTH (XCNT_WIDTH),
        .MAX   (X_MEM_SIZE)
    ) u_x_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q == ST_DONE),
        .inc   (x_wr_en),
        .count (x_count)
    );

`ifdef CONV_OUT_PERF_EN
    // Cycles a result sat unaccepted downstream during the current frame
    sat_counter #(
        .WIDTH (16),
        .MAX   (16'hFFFF)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_start),
        .inc   ((state_q == ST_OUT) && !m_ready_y),
        .count (stall_cnt)
    );
`else
    assign stall_cnt = 16'h0000;
`endif

    assign x_base_addr = x_base_addr_q;
    assign f_sel       = f_sel_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/conv_out_sequencer.md
CONV_OUT_SEQUENCER -- requirements
Module: conv_out_sequencer

Interface
REQ-001 SHALL have parameter X_MEM_SIZE, default 8, meaning number of X words per frame.
REQ-002 SHALL have parameter F_MEM_SIZE, default 4, meaning filter taps; the legal range is 1..X_MEM_SIZE.
REQ-003 SHALL have parameter STRIDE, default 1, meaning window advance in X words; (X_MEM_SIZE-F_MEM_SIZE) SHALL be divisible by STRIDE.
REQ-004 SHALL have parameter NUM_F, default 1, meaning filters applied per window position.
REQ-005 SHALL derive localparams X_MEM_ADDR_WIDTH=$clog2(X_MEM_SIZE), F_SEL_WIDTH=max(1,$clog2(NUM_F)), N_OUT=(X_MEM_SIZE-F_MEM_SIZE)/STRIDE+1.
REQ-006 SHALL have clk  input  1  sole clock, rising edge.
REQ-007 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have conv_start  input  1  level; its rising edge starts a frame.
REQ-009 SHALL have x_wr_en  input  1  one X word written this cycle.
REQ-010 SHALL have mac_done  input  1  one-cycle pulse from datapath: result ready.
REQ-011 SHALL have m_ready_y  input  1  downstream ready.
REQ-012 SHALL have mac_start  output  1  one-cycle pulse: start MAC on current window.
REQ-013 SHALL have x_base_addr  output  X_MEM_ADDR_WIDTH  first X address of current window.
REQ-014 SHALL have f_sel  output  F_SEL_WIDTH  current filter index.
REQ-015 SHALL have m_valid_y  output  1  y result valid.
REQ-016 SHALL have y_last  output  1  marks final y of frame, qualified by m_valid_y.
REQ-017 SHALL have conv_done  output  1  one-cycle pulse at end of frame.
REQ-018 SHALL have busy  output  1  high in every state except IDLE.
REQ-019 SHALL have stall_cnt  output  16  output back-pressure cycle count.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT_X, ISSUE, MAC, OUT, DONE.
REQ-021 SHALL transition IDLE->WAIT_X on conv_start high with registered conv_start low, which clears position and filter indices; conv_start is ignored outside IDLE.
REQ-022 SHALL keep x_count (0..X_MEM_SIZE, saturating) incremented by x_wr_en in all states; x_count becomes x_wr_en in the DONE cycle.
REQ-023 SHALL transition WAIT_X->ISSUE when x_count >= pos*STRIDE+F_MEM_SIZE, same-cycle x_wr_en included.
REQ-024 SHALL hold mac_start=1 in ISSUE only (exactly one cycle), then go to MAC.
REQ-025 SHALL transition MAC->OUT on mac_done; mac_done outside MAC is ignored.
REQ-026 SHALL assert m_valid_y in OUT only; it SHALL NOT drop before m_valid_y&&m_ready_y.
REQ-027 SHALL, on OUT handshake, advance f_sel first, then pos with f_sel wrap, then go to WAIT_X; on the handshake of the last (pos=N_OUT-1, f_sel=NUM_F-1) go to DONE.
REQ-028 SHALL drive y_last=1 during OUT only for the last result.
REQ-029 SHALL assert conv_done in DONE for one cycle, then return to IDLE.
REQ-030 SHALL drive x_base_addr=pos*STRIDE as a registered value, stable from ISSUE through OUT.

Reset
REQ-031 SHALL, with reset low, asynchronously force state IDLE, all counters 0, and mac_start, m_valid_y, y_last, conv_done, busy, x_base_addr, f_sel, stall_cnt to 0.
REQ-032 SHALL abandon a frame on reset mid-operation with no conv_done; after reset deasserts, a new conv_start rising edge is required.

Configuration
REQ-033 SHALL, with CONV_OUT_PERF_EN defined, count cycles in OUT with m_ready_y=0 into stall_cnt, saturating at 16'hFFFF and cleared on IDLE->WAIT_X.
REQ-034 SHALL, without CONV_OUT_PERF_EN, keep port stall_cnt tied to 0 and instantiate no counter logic.

Structure
REQ-035 SHALL place the state enum typedef and the N_OUT computation function in shared package conv_pkg.
REQ-036 SHALL use one sub-module, sat_counter (parametrised width/max, inc, clear), for x_count and stall_cnt.

Verification
REQ-037 SHALL test defaults with X preloaded (8 writes), then start, m_ready_y=1 -> 5 results, x_base_addr 0,1,2,3,4, y_last on 5th, then conv_done pulse.
REQ-038 SHALL test STRIDE=2, NUM_F=2 -> 6 results, (addr,f_sel) = (0,0),(0,1),(2,0),(2,1),(4,0),(4,1).
REQ-039 SHALL test streaming: start with x_count=0 and one write every 3 cycles -> first mac_start only after 4th write, window p only after write p+4.
REQ-040 SHALL test m_ready_y low for 7 cycles on 2nd result -> m_valid_y, x_base_addr held; stall_cnt=7 with CONV_OUT_PERF_EN, 0 without.
REQ-041 SHALL test reset low during MAC -> all outputs 0 immediately; later conv_start held high without a new edge -> stays IDLE.
